// File: rtl/per_pkg.sv
// per_pkg: shared sequencer state type and core control words.
package per_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_FIN
  } per_seq_state_t;

  localparam logic [3:0] CTRL_IDLE = 4'b0000;
  localparam logic [3:0] CTRL_RUN  = 4'b1111;

endpackage

// File: rtl/per_seq_timer.sv
// per_seq_timer: loadable down-counter with terminal-count flag.
//   load/load_val : start a phase lasting load_val cycles (load_val >= 1)
//   tc            : high on the last cycle of the loaded phase
module per_seq_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val - W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/per_train_seq.sv
// per_train_seq: perceptron training sequencer (load/run per sample, epochs).
//   in : clk, rst, start, abort, core_done
//   out: core_rst, core_ctrl, sample_addr, epoch, busy, done, timeout
// Optional macro PER_SEQ_ERRCNT_EN adds core_err, err_cnt, last_err,
// converged and early stop on an error-free epoch.
module per_train_seq
  import per_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned N_SAMPLES = 501,
  parameter int unsigned N_EPOCHS  = 1,
  parameter int unsigned LOAD_CYC  = 5,
  parameter int unsigned RUN_CYC   = 30,
  parameter int unsigned EP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              core_done,
`ifdef PER_SEQ_ERRCNT_EN
  input  logic              core_err,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W:0]   last_err,
  output logic              converged,
`endif
  output logic              core_rst,
  output logic [3:0]        core_ctrl,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [EP_W-1:0]   epoch,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned MAXC = (LOAD_CYC > RUN_CYC) ? LOAD_CYC : RUN_CYC;
  localparam int unsigned TW   = $clog2(MAXC) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [EP_W-1:0]   EP_MAX    = '1;

  per_seq_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [EP_W-1:0]   epoch_q, epoch_d, epoch_inc;
  logic              to_q, to_d;
  logic              core_rst_q, busy_q, done_q;
  logic [3:0]        ctrl_q;
  logic              tmr_load, tmr_tc;
  logic [TW-1:0]     tmr_val;
`ifdef PER_SEQ_ERRCNT_EN
  logic [ADDR_W:0]   err_q, err_d, last_q, last_d;
  logic              conv_q, conv_d;
`endif

  per_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    epoch_d   = epoch_q;
    to_d      = to_q;
    tmr_load  = 1'b0;
    tmr_val   = TW'(LOAD_CYC);
    epoch_inc = (epoch_q == EP_MAX) ? epoch_q : epoch_q + EP_W'(1);
`ifdef PER_SEQ_ERRCNT_EN
    err_d     = err_q;
    last_d    = last_q;
    conv_d    = conv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_LOAD;
          addr_d   = '0;
          epoch_d  = '0;
          to_d     = 1'b0;
          tmr_load = 1'b1;
`ifdef PER_SEQ_ERRCNT_EN
          err_d    = '0;
          last_d   = '0;
          conv_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (tmr_tc) begin
          state_d  = S_RUN;
          tmr_load = 1'b1;
          tmr_val  = TW'(RUN_CYC);
        end
      end
      S_RUN: begin
        // core_done on the final allowed cycle beats the timeout
        if (core_done) begin
          state_d = S_NEXT;
`ifdef PER_SEQ_ERRCNT_EN
          if (core_err) err_d = err_q + (ADDR_W+1)'(1);
`endif
        end else if (tmr_tc) begin
          state_d = S_NEXT;
          to_d    = 1'b1;
        end
      end
      S_NEXT: begin
        if (addr_q != LAST_ADDR) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LOAD;
        end else begin
          addr_d  = '0;
          epoch_d = epoch_inc;
          state_d = (32'(epoch_inc) == N_EPOCHS) ? S_FIN : S_LOAD;
`ifdef PER_SEQ_ERRCNT_EN
          last_d = err_q;
          err_d  = '0;
          if (err_q == '0) begin
            conv_d  = 1'b1;
            state_d = S_FIN;
          end
`endif
        end
        tmr_load = (state_d == S_LOAD);
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides every per-state update except the address clear
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
      epoch_d = epoch_q;
      to_d    = to_q;
`ifdef PER_SEQ_ERRCNT_EN
      err_d   = err_q;
      last_d  = last_q;
      conv_d  = conv_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      epoch_q    <= '0;
      to_q       <= 1'b0;
      core_rst_q <= 1'b0;
      ctrl_q     <= CTRL_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PER_SEQ_ERRCNT_EN
      err_q      <= '0;
      last_q     <= '0;
      conv_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      epoch_q    <= epoch_d;
      to_q       <= to_d;
      core_rst_q <= (state_d == S_LOAD);
      ctrl_q     <= (state_d == S_RUN) ? CTRL_RUN : CTRL_IDLE;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FIN);
`ifdef PER_SEQ_ERRCNT_EN
      err_q      <= err_d;
      last_q     <= last_d;
      conv_q     <= conv_d;
`endif
    end
  end

  assign core_rst    = core_rst_q;
  assign core_ctrl   = ctrl_q;
  assign sample_addr = addr_q;
  assign epoch       = epoch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = to_q;
`ifdef PER_SEQ_ERRCNT_EN
  assign err_cnt     = err_q;
  assign last_err    = last_q;
  assign converged   = conv_q;
`endif

endmodule

// File: tb/tb_per_train_seq.sv
// tb_per_train_seq: randomized self-checking bench for per_train_seq.
// Expected outputs come from a per-job cycle timeline built from the
// sample/epoch rules (segments of load, run, next and fin cycles).
module tb_per_train_seq;

  localparam int AW = 3;
  localparam int NS = 8;
  localparam int NE = 2;
  localparam int LC = 5;
  localparam int RC = 30;
  localparam int EW = 8;

  localparam int K_LOAD = 1;
  localparam int K_RUN  = 2;
  localparam int K_NEXT = 3;
  localparam int K_FIN  = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, core_done, core_err;
  logic          core_rst, busy, done, timeout;
  logic [3:0]    core_ctrl;
  logic [AW-1:0] sample_addr;
  logic [EW-1:0] epoch;
`ifdef PER_SEQ_ERRCNT_EN
  logic [AW:0]   err_cnt, last_err;
  logic          converged;
`endif

  always #5 clk = ~clk;

  per_train_seq #(
    .ADDR_W    (AW),
    .N_SAMPLES (NS),
    .N_EPOCHS  (NE),
    .LOAD_CYC  (LC),
    .RUN_CYC   (RC),
    .EP_W      (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .core_done   (core_done),
`ifdef PER_SEQ_ERRCNT_EN
    .core_err    (core_err),
    .err_cnt     (err_cnt),
    .last_err    (last_err),
    .converged   (converged),
`endif
    .core_rst    (core_rst),
    .core_ctrl   (core_ctrl),
    .sample_addr (sample_addr),
    .epoch       (epoch),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  int total = 0;
  int bad   = 0;
  int cur_t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0d: got %0h want %0h", tag, cur_t, obs, exp);
    end
  endtask

  typedef struct {
    int kind;
    int addr;
    int ep;
    bit to;
    bit drv_done;
    bit drv_err;
  } cyc_t;

  cyc_t tl[$];
  int   exp_last;
  bit   exp_conv;

  function automatic cyc_t mk(int kind, int addr, int ep, bit to, bit dd, bit de);
    cyc_t c;
    c.kind = kind; c.addr = addr; c.ep = ep; c.to = to;
    c.drv_done = dd; c.drv_err = de;
    return c;
  endfunction

  function automatic int pick_d();
    case ($urandom_range(0, 4))
      0: return 1;
      1: return RC - 1;
      2: return RC;
      3: return RC + 1;
      default: return $urandom_range(1, RC + 10);
    endcase
  endfunction

  // modes: 0 done after 10 run cycles, 1 never done, 2 random,
  // 3 done after 10 with errors on samples 0,1 of epoch 0
  task automatic build(input int mode);
    bit to;
    int eps, errs;
    bit noisy;
    to = 0; eps = 0; exp_last = 0; exp_conv = 0;
    noisy = (mode == 2);
    tl.delete();
    for (int e = 0; e < NE; e++) begin
      errs = 0;
      for (int s = 0; s < NS; s++) begin
        int d, r;
        bit hit, er;
        d   = (mode == 2) ? pick_d() : (mode == 1) ? RC + 1 : 10;
        hit = (d <= RC);
        r   = hit ? d : RC;
        er  = (mode == 2) ? ($urandom_range(0, 3) == 0) : (mode == 3 && e == 0 && s < 2);
        for (int i = 0; i < LC; i++)
          tl.push_back(mk(K_LOAD, s, e, to, noisy & $urandom_range(0, 1), noisy & $urandom_range(0, 1)));
        for (int i = 0; i < r; i++) begin
          if (i == r - 1)
            tl.push_back(mk(K_RUN, s, e, to, hit, er));
          else
            tl.push_back(mk(K_RUN, s, e, to, 1'b0, noisy & $urandom_range(0, 1)));
        end
        if (hit && er) errs++;
        if (!hit) to = 1;
        tl.push_back(mk(K_NEXT, s, e, to, noisy & $urandom_range(0, 1), 1'b0));
      end
      eps = e + 1;
      exp_last = errs;
`ifdef PER_SEQ_ERRCNT_EN
      if (errs == 0) begin
        exp_conv = 1;
        break;
      end
`endif
    end
    tl.push_back(mk(K_FIN, 0, eps, to, noisy & $urandom_range(0, 1), 1'b0));
  endtask

  task automatic chk_idle(input string ctx, input bit ep_known, input int ep, input bit to);
    chk({ctx, ".busy"}, 32'(busy), 0);
    chk({ctx, ".done"}, 32'(done), 0);
    chk({ctx, ".core_rst"}, 32'(core_rst), 0);
    chk({ctx, ".core_ctrl"}, 32'(core_ctrl), 0);
    chk({ctx, ".addr"}, 32'(sample_addr), 0);
    if (ep_known) begin
      chk({ctx, ".epoch"}, 32'(epoch), 32'(ep));
      chk({ctx, ".timeout"}, 32'(timeout), 32'(to));
    end
  endtask

  // cut_kind: 0 none, 1 abort, 2 reset; cut_at < 0 picks a random cycle
  task automatic run_job(input int mode, input int cut_kind, input int cut_at);
    cyc_t c;
    int   at;
    bit   ep_known;
    int   idle_ep;
    bit   idle_to;
    build(mode);
    at = (cut_at < 0) ? $urandom_range(1, tl.size()) : cut_at;
    ep_known = 1;
    idle_ep  = tl[tl.size() - 1].ep;
    idle_to  = tl[tl.size() - 1].to;
    start = 1'b1;
    for (int t = 1; t <= tl.size(); t++) begin
      @(posedge clk); #1;
      cur_t = t;
      c = tl[t - 1];
      chk("core_rst", 32'(core_rst), 32'(c.kind == K_LOAD));
      chk("core_ctrl", 32'(core_ctrl), (c.kind == K_RUN) ? 32'hF : 32'h0);
      chk("addr", 32'(sample_addr), 32'(c.addr));
      chk("epoch", 32'(epoch), 32'(c.ep));
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), 32'(c.kind == K_FIN));
      chk("timeout", 32'(timeout), 32'(c.to));
`ifdef PER_SEQ_ERRCNT_EN
      if (c.kind == K_FIN) begin
        chk("last_err", 32'(last_err), 32'(exp_last));
        chk("converged", 32'(converged), 32'(exp_conv));
        chk("err_cnt", 32'(err_cnt), 0);
      end
`endif
      start     = 1'($urandom_range(0, 1));
      core_done = c.drv_done;
      core_err  = c.drv_err;
      if (cut_kind != 0 && t == at) begin
        if (cut_kind == 1) abort = 1'b1;
        else rst = 1'b1;
        @(posedge clk); #1;
        cur_t = t + 1;
        start = 1'b0; abort = 1'b0; rst = 1'b0; core_done = 1'b0;
        if (cut_kind == 1) begin
          ep_known = (c.kind != K_NEXT);
          idle_ep  = c.ep;
          idle_to  = c.to;
          chk_idle("abort", ep_known, idle_ep, idle_to);
        end else begin
          ep_known = 1;
          idle_ep  = 0;
          idle_to  = 0;
          chk_idle("reset", 1, 0, 0);
        end
        break;
      end
    end
    start = 1'b0; abort = 1'b0; core_done = 1'b0; core_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cur_t++;
      chk_idle("idle", ep_known, idle_ep, idle_to);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; core_done = 1'b0; core_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset", 1, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(0, 0, 0);
    run_job(1, 0, 0);
    run_job(3, 0, 0);
    // abort on the 3rd run cycle of sample 2 (16 cycles per sample)
    run_job(0, 1, 2 * (LC + 10 + 1) + LC + 3);
    run_job(0, 0, 0);
    // reset on the 2nd run cycle of sample 0
    run_job(0, 2, LC + 2);

    // start and abort together in idle: stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    cur_t = 0;
    chk("start_abort.busy", 32'(busy), 0);
    chk("start_abort.core_rst", 32'(core_rst), 0);
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    chk("start_abort.busy2", 32'(busy), 0);

    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0: run_job(2, 1, -1);
        1: run_job(2, 2, -1);
        default: run_job(2, 0, 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
